// File: rtl/ring_link_arbiter.sv
// ring_link_arbiter
//   Shares one outgoing ring link among three requesters using round-robin
//   arbitration. Downstream buffer space is tracked with a credit counter.
//   Requester 0 is clockwise through-traffic, requester 1 is turned traffic
//   and requester 2 is local injection.
//
// Ports
//   i_clk             rising-edge clock
//   i_rst             asynchronous active-high reset
//   i_req_valid[2:0]  per-requester word valid
//   i_req_data        requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_req_ready[2:0]  one-hot grant (or zero); accept when valid & ready
//   o_link_valid      registered link word valid
//   o_link_data       registered link word
//   o_link_src        registered source index, 2'b11 when link idle
//   i_credit_return   downstream freed one buffer slot this cycle
//   o_credits         current credit count
//   o_credit_overflow sticky error: credit returned while counter was full
module ring_link_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_CREDITS  = 4,
  parameter int CREDIT_WIDTH = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [2:0]                i_req_valid,
  input  logic [3*DATA_WIDTH-1:0]   i_req_data,
  output logic [2:0]                o_req_ready,
  output logic                      o_link_valid,
  output logic [DATA_WIDTH-1:0]     o_link_data,
  output logic [1:0]                o_link_src,
  input  logic                      i_credit_return,
  output logic [CREDIT_WIDTH-1:0]   o_credits,
  output logic                      o_credit_overflow
);

  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(NUM_CREDITS);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_ONE = CREDIT_WIDTH'(1);

  logic [1:0]              r_rr_ptr;
  logic [CREDIT_WIDTH-1:0] r_credits;
  logic                    r_link_valid;
  logic [DATA_WIDTH-1:0]   r_link_data;
  logic [1:0]              r_link_src;
  logic                    r_credit_overflow;

  logic [DATA_WIDTH-1:0]   w_words [3];
  logic [1:0]              w_cand;
  logic [1:0]              w_grant_idx;
  logic                    w_send;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_word_slice
      assign w_words[gi] = i_req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // (a + b) mod 3 for a, b in 0..2
  function automatic logic [1:0] wrap_add3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Scan offsets from farthest to nearest so the requester closest to
  // r_rr_ptr overwrites any earlier candidate and wins. credit_return is
  // deliberately not an input here: grants only use the registered count.
  always_comb begin
    w_cand      = 2'd0;
    w_grant_idx = 2'd0;
    w_send      = 1'b0;
    if (r_credits != '0) begin
      for (int k = 2; k >= 0; k--) begin
        w_cand = wrap_add3(r_rr_ptr, 2'(k));
        if (i_req_valid[w_cand]) begin
          w_grant_idx = w_cand;
          w_send      = 1'b1;
        end
      end
    end
  end

  assign o_req_ready = w_send ? (3'b001 << w_grant_idx) : 3'b000;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr          <= 2'd0;
      r_credits         <= CREDIT_MAX;
      r_link_valid      <= 1'b0;
      r_link_data       <= '0;
      r_link_src        <= 2'b11;
      r_credit_overflow <= 1'b0;
    end else begin
      if (w_send) begin
        r_link_valid <= 1'b1;
        r_link_data  <= w_words[w_grant_idx];
        r_link_src   <= w_grant_idx;
        r_rr_ptr     <= wrap_add3(w_grant_idx, 2'd1);
      end else begin
        // link_data intentionally holds its last value when idle
        r_link_valid <= 1'b0;
        r_link_src   <= 2'b11;
      end

      unique case ({w_send, i_credit_return})
        2'b10: r_credits <= r_credits - CREDIT_ONE;
        2'b01: begin
          if (r_credits == CREDIT_MAX) begin
            r_credit_overflow <= 1'b1;
          end else begin
            r_credits <= r_credits + CREDIT_ONE;
          end
        end
        default: r_credits <= r_credits;
      endcase
    end
  end

  assign o_link_valid      = r_link_valid;
  assign o_link_data       = r_link_data;
  assign o_link_src        = r_link_src;
  assign o_credits         = r_credits;
  assign o_credit_overflow = r_credit_overflow;

endmodule

// File: tb/tb_ring_link_arbiter.sv
module tb_ring_link_arbiter;

  localparam int DW    = 32;
  localparam int NC    = 4;
  localparam int CW    = 3;
  localparam int DEPTH = 512;

  logic            clk;
  logic            rst;
  logic [2:0]      req_valid;
  logic [3*DW-1:0] req_data;
  logic [2:0]      req_ready;
  logic            link_valid;
  logic [DW-1:0]   link_data;
  logic [1:0]      link_src;
  logic            credit_return;
  logic [CW-1:0]   credits;
  logic            credit_overflow;

  ring_link_arbiter #(.DATA_WIDTH(DW), .NUM_CREDITS(NC), .CREDIT_WIDTH(CW)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_req_valid       (req_valid),
    .i_req_data        (req_data),
    .o_req_ready       (req_ready),
    .o_link_valid      (link_valid),
    .o_link_data       (link_data),
    .o_link_src        (link_src),
    .i_credit_return   (credit_return),
    .o_credits         (credits),
    .o_credit_overflow (credit_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Requester word queues (array-based FIFOs) - a word stays at the head
  // until it is accepted.
  logic [DW-1:0] mem [3][DEPTH];
  int            rd  [3];
  int            wr  [3];
  logic [2:0]    cur_valid;

  // Reference model state
  int            m_rr;
  int            m_cred;
  bit            m_ovf;
  bit            m_lv;
  logic [DW-1:0] m_ld;
  logic [1:0]    m_ls;
  logic [2:0]    obs_ready;
  logic [2:0]    exp_ready;
  int            last_g;

  function automatic void push(input int i, input logic [DW-1:0] w);
    if (wr[i] < DEPTH) begin
      mem[i][wr[i]] = w;
      wr[i]++;
    end
  endfunction

  // Winner = valid requester at the smallest forward distance from the pointer.
  function automatic int pick(input logic [2:0] v, input int rr, input int cred);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = 99;
    if (cred == 0) return -1;
    for (int i = 0; i < 3; i++) begin
      if (v[i]) begin
        d = (i - rr + 3) % 3;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_rr   = 0;
    m_cred = NC;
    m_ovf  = 0;
    m_lv   = 0;
    m_ld   = '0;
    m_ls   = 2'b11;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    req_valid     = 3'b000;
    req_data      = '0;
    credit_return = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd[i] = 0;
      wr[i] = 0;
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents queue heads, advances one clock edge and updates the model.
  task automatic tick(input bit ret);
    int            g;
    logic [3*DW-1:0] d;
    d = '0;
    for (int i = 0; i < 3; i++) begin
      cur_valid[i] = (rd[i] < wr[i]);
      if (cur_valid[i]) d[i*DW +: DW] = mem[i][rd[i]];
    end
    req_valid     = cur_valid;
    req_data      = d;
    credit_return = ret;
    #1;
    obs_ready = req_ready;
    g = pick(cur_valid, m_rr, m_cred);
    exp_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
    @(posedge clk);
    #1;
    if (g >= 0) begin
      m_lv = 1;
      m_ld = mem[g][rd[g]];
      m_ls = 2'(g);
      m_rr = (g + 1) % 3;
      rd[g]++;
    end else begin
      m_lv = 0;
      m_ls = 2'b11;
    end
    m_cred = m_cred - ((g >= 0) ? 1 : 0) + (ret ? 1 : 0);
    if (m_cred > NC) begin
      m_cred = NC;
      m_ovf  = 1;
    end
    last_g = g;
    if (link_valid) $display("[TB] xfer src=%0d data=%h credits=%0d", link_src, link_data, credits);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (link_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", link_valid); end
    n_tests++; if (link_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", link_data); end
    n_tests++; if (link_src !== 2'b11) begin n_fail++; $display("FAIL reset_src got=%0d exp=3", link_src); end
    n_tests++; if (credits !== CW'(NC)) begin n_fail++; $display("FAIL reset_credits got=%0d exp=%0d", credits, NC); end
    n_tests++; if (credit_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", credit_overflow); end
    n_tests++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    for (int i = 0; i < 3; i++) for (int k = 0; k < 4; k++) push(i, $urandom);
    tick(0);
    tick(0);
    n_tests++; if (link_valid !== 1'b1 || credits !== CW'(m_cred)) begin
      n_fail++; $display("FAIL pre_reset got v=%b c=%0d exp v=1 c=%0d", link_valid, credits, m_cred);
    end
    // Asynchronous reset mid-transfer, checked well before the next edge.
    #3;
    rst = 1'b1;
    #1;
    n_tests++; if (link_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid got=%b exp=0", link_valid); end
    n_tests++; if (link_src !== 2'b11) begin n_fail++; $display("FAIL async_src got=%0d exp=3", link_src); end
    n_tests++; if (credits !== CW'(NC)) begin n_fail++; $display("FAIL async_credits got=%0d exp=%0d", credits, NC); end
    n_tests++; if (credit_overflow !== 1'b0) begin n_fail++; $display("FAIL async_ovf got=%b exp=0", credit_overflow); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick(0);
    n_tests++; if (link_valid !== 1'b1 || link_src !== 2'd0 || link_data !== m_ld) begin
      n_fail++; $display("FAIL post_reset_first got v=%b src=%0d d=%h exp v=1 src=0 d=%h", link_valid, link_src, link_data, m_ld);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [6];
    seq = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    do_reset();
    for (int i = 0; i < 3; i++) for (int k = 0; k < 3; k++) push(i, $urandom);
    for (int c = 0; c < 6; c++) begin
      tick(1);
      n_tests++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, obs_ready, exp_ready); end
      n_tests++; if (link_valid !== 1'b1 || link_src !== seq[c] || link_data !== m_ld) begin
        n_fail++; $display("FAIL rr_src c=%0d got v=%b src=%0d d=%h exp v=1 src=%0d d=%h", c, link_valid, link_src, link_data, seq[c], m_ld);
      end
      n_tests++; if (credits !== CW'(NC)) begin n_fail++; $display("FAIL rr_credits c=%0d got=%0d exp=%0d", c, credits, NC); end
    end
  endtask

  task automatic test_skip_pointer();
    logic [1:0] seq [4];
    seq = '{2'd0, 2'd2, 2'd0, 2'd2};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push(0, $urandom);
      push(2, $urandom);
    end
    for (int c = 0; c < 4; c++) begin
      tick(1);
      n_tests++; if (link_valid !== 1'b1 || link_src !== seq[c]) begin
        n_fail++; $display("FAIL skip_src c=%0d got v=%b src=%0d exp v=1 src=%0d", c, link_valid, link_src, seq[c]);
      end
    end
    // Last grant went to 2: newly valid requester 1 must lose to 0.
    push(1, $urandom);
    tick(1);
    n_tests++; if (obs_ready !== 3'b001 || link_src !== 2'd0) begin
      n_fail++; $display("FAIL skip_ptr got ready=%b src=%0d exp ready=001 src=0", obs_ready, link_src);
    end
    tick(1);
    n_tests++; if (link_src !== 2'd1 || link_data !== m_ld) begin
      n_fail++; $display("FAIL skip_next got src=%0d d=%h exp src=1 d=%h", link_src, link_data, m_ld);
    end
  endtask

  task automatic test_credit_exhaustion();
    do_reset();
    for (int k = 0; k < 6; k++) push(1, $urandom);
    for (int c = 0; c < 4; c++) begin
      tick(0);
      n_tests++; if (link_valid !== 1'b1 || link_src !== 2'd1 || credits !== CW'(NC - 1 - c)) begin
        n_fail++; $display("FAIL exh_send c=%0d got v=%b src=%0d cr=%0d exp v=1 src=1 cr=%0d", c, link_valid, link_src, credits, NC - 1 - c);
      end
    end
    tick(0);
    n_tests++; if (obs_ready !== 3'b000 || link_valid !== 1'b0 || credits !== '0) begin
      n_fail++; $display("FAIL exh_stall got ready=%b v=%b cr=%0d exp ready=000 v=0 cr=0", obs_ready, link_valid, credits);
    end
    tick(1);  // credit pulse sampled at this edge
    n_tests++; if (obs_ready !== 3'b000 || link_valid !== 1'b0 || credits !== CW'(1)) begin
      n_fail++; $display("FAIL exh_pulse got ready=%b v=%b cr=%0d exp ready=000 v=0 cr=1", obs_ready, link_valid, credits);
    end
    tick(0);
    n_tests++; if (obs_ready !== 3'b010 || link_valid !== 1'b1 || link_data !== m_ld || credits !== '0) begin
      n_fail++; $display("FAIL exh_one got ready=%b v=%b d=%h cr=%0d exp ready=010 v=1 d=%h cr=0", obs_ready, link_valid, link_data, credits, m_ld);
    end
    tick(0);
    n_tests++; if (link_valid !== 1'b0 || obs_ready !== 3'b000) begin
      n_fail++; $display("FAIL exh_only_one got v=%b ready=%b exp v=0 ready=000", link_valid, obs_ready);
    end
  endtask

  task automatic test_send_and_return();
    do_reset();
    for (int k = 0; k < 6; k++) push(0, $urandom);
    tick(0); tick(0); tick(0);
    n_tests++; if (credits !== CW'(1)) begin n_fail++; $display("FAIL sr_setup got=%0d exp=1", credits); end
    tick(1);
    n_tests++; if (link_valid !== 1'b1 || credits !== CW'(1)) begin
      n_fail++; $display("FAIL sr_same got v=%b cr=%0d exp v=1 cr=1", link_valid, credits);
    end
    tick(0);
    n_tests++; if (obs_ready !== 3'b001 || link_valid !== 1'b1 || link_data !== m_ld || credits !== '0) begin
      n_fail++; $display("FAIL sr_next got ready=%b v=%b cr=%0d exp ready=001 v=1 cr=0", obs_ready, link_valid, credits);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    tick(1);
    n_tests++; if (credits !== CW'(NC) || credit_overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set got cr=%0d ovf=%b exp cr=%0d ovf=1", credits, credit_overflow, NC);
    end
    for (int k = 0; k < 3; k++) push(k, $urandom);
    for (int c = 0; c < 5; c++) begin
      tick(c[0]);
      n_tests++; if (credit_overflow !== 1'b1 || credits !== CW'(m_cred)) begin
        n_fail++; $display("FAIL ovf_sticky c=%0d got ovf=%b cr=%0d exp ovf=1 cr=%0d", c, credit_overflow, credits, m_cred);
      end
    end
    do_reset();
    n_tests++; if (credit_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", credit_overflow); end
  endtask

  task automatic test_random();
    bit ret;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) if ($urandom_range(0, 2) == 0) push(i, $urandom);
      ret = (m_cred < NC) && ($urandom_range(0, 1) == 1);
      tick(ret);
      n_tests++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, obs_ready, exp_ready); end
      n_tests++; if (link_valid !== m_lv || link_src !== m_ls || link_data !== m_ld) begin
        n_fail++; $display("FAIL rnd_link c=%0d got v=%b src=%0d d=%h exp v=%b src=%0d d=%h", c, link_valid, link_src, link_data, m_lv, m_ls, m_ld);
      end
      n_tests++; if (credits !== CW'(m_cred) || credit_overflow !== m_ovf) begin
        n_fail++; $display("FAIL rnd_credit c=%0d got cr=%0d ovf=%b exp cr=%0d ovf=%b", c, credits, credit_overflow, m_cred, m_ovf);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    req_valid     = 3'b000;
    req_data      = '0;
    credit_return = 1'b0;
    test_reset();
    test_round_robin();
    test_skip_pointer();
    test_credit_exhaustion();
    test_send_and_return();
    test_overflow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
